// File: rtl/bigadder_seq_pkg.sv
// -----------------------------------------------------------------------------
// bigadder_pkg
// Shared definitions for the bigadder_seq wide-add sequencer:
//   SLICE_W       - width of the shared adder slice (fixed at 16)
//   WORDS_DEFAULT - default number of slices per operand
//   state_t       - sequencer FSM states (IDLE / RUN / DONE)
// -----------------------------------------------------------------------------
package bigadder_pkg;

    localparam int SLICE_W       = 16;
    localparam int WORDS_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bigadder_seq_if.sv
// -----------------------------------------------------------------------------
// bigadder_seq_if
// Job / result handshake bundle for bigadder_seq.
//   in_valid/in_ready  - job handshake (a_in, b_in, c_in, op_sub)
//   out_valid/out_ready- result handshake (sum_out, c_out, ovf_out)
//   busy               - sequencer is in RUN or DONE
// Optional feature macro: BIGADDER_SEQ_SUB_EN adds the op_sub signal.
// Modports: master = requester/consumer side, slave = bigadder_seq.
// -----------------------------------------------------------------------------
interface bigadder_seq_if #(
    parameter int WORDS = bigadder_pkg::WORDS_DEFAULT
);
    import bigadder_pkg::*;

    localparam int W = SLICE_W * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         c_in;
`ifdef BIGADDER_SEQ_SUB_EN
    logic         op_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum_out;
    logic         c_out;
    logic         ovf_out;
    logic         busy;

`ifdef BIGADDER_SEQ_SUB_EN
    modport master (
        output in_valid, a_in, b_in, c_in, op_sub, out_ready,
        input  in_ready, out_valid, sum_out, c_out, ovf_out, busy
    );
    modport slave (
        input  in_valid, a_in, b_in, c_in, op_sub, out_ready,
        output in_ready, out_valid, sum_out, c_out, ovf_out, busy
    );
`else
    modport master (
        output in_valid, a_in, b_in, c_in, out_ready,
        input  in_ready, out_valid, sum_out, c_out, ovf_out, busy
    );
    modport slave (
        input  in_valid, a_in, b_in, c_in, out_ready,
        output in_ready, out_valid, sum_out, c_out, ovf_out, busy
    );
`endif

endinterface

// File: rtl/bigadder_seq_add16_slice.sv
// -----------------------------------------------------------------------------
// add16_slice
// Combinational 16-bit adder slice shared across all slices of a wide add.
//   a, b : 16-bit addends      ci : carry in
//   s    : 16-bit sum          co : carry out
// -----------------------------------------------------------------------------
module add16_slice (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [15:0] s,
    output logic        co
);

    // Single 17-bit add; bit 16 is the slice carry-out.
    assign {co, s} = {1'b0, a} + {1'b0, b} + {16'd0, ci};

endmodule

// File: rtl/bigadder_seq.sv
// -----------------------------------------------------------------------------
// bigadder_seq
// Adds two WORDS x 16-bit operands one 16-bit slice per clock through a
// single shared add16_slice, low slice first, carry chained via a register.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - bigadder_seq_if.slave (job in, result out, busy)
// Optional feature macro: BIGADDER_SEQ_SUB_EN enables A-B via op_sub.
// Latency is WORDS cycles from the accept edge to out_valid.
// -----------------------------------------------------------------------------
module bigadder_seq
    import bigadder_pkg::*;
#(
    parameter int WORDS = WORDS_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    bigadder_seq_if.slave  bus
);

    localparam int W     = SLICE_W * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;       // holds B_eff (already inverted for subtract)
    logic [W-1:0]       sum_q, sum_d;
    logic               cy_q, cy_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               co_q, co_d;
    logic               ovf_q, ovf_d;

    logic               accept_s;
    logic               last_s;
    logic [IDX_W+3:0]   base_s;
    logic [W-1:0]       b_load_s;
    logic               cy_load_s;
    logic [15:0]        slice_sum_s;
    logic               slice_co_s;
    logic               in_ready_s;
    logic               out_valid_s;
    logic               busy_s;

    assign accept_s = bus.in_valid && (state_q == IDLE);
    assign last_s   = (idx_q == LAST_IDX);
    // Slice width is 16, so the bit offset of slice k is k followed by four zeros.
    assign base_s   = {idx_q, 4'd0};

    add16_slice u_slice (
        .a  (a_q[base_s +: SLICE_W]),
        .b  (b_q[base_s +: SLICE_W]),
        .ci (cy_q),
        .s  (slice_sum_s),
        .co (slice_co_s)
    );

    // Operand/carry values captured on accept; subtract folds into ~B with carry 1.
    always_comb begin
        b_load_s  = bus.b_in;
        cy_load_s = bus.c_in;
`ifdef BIGADDER_SEQ_SUB_EN
        if (bus.op_sub) begin
            b_load_s  = ~bus.b_in;
            cy_load_s = 1'b1;
        end else begin
            b_load_s  = bus.b_in;
            cy_load_s = bus.c_in;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) state_d = RUN;
                else          state_d = IDLE;
            end
            RUN: begin
                if (last_s) state_d = DONE;
                else        state_d = RUN;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
                else               state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs, decoded from the state register only.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
        case (state_q)
            IDLE:    in_ready_s  = 1'b1;
            RUN:     busy_s      = 1'b1;
            DONE: begin
                out_valid_s = 1'b1;
                busy_s      = 1'b1;
            end
            default: in_ready_s  = 1'b0;
        endcase
    end

    // Datapath next-state: load on accept, one slice per RUN cycle.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        sum_d = sum_q;
        cy_d  = cy_q;
        idx_d = idx_q;
        co_d  = co_q;
        ovf_d = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    a_d   = bus.a_in;
                    b_d   = b_load_s;
                    cy_d  = cy_load_s;
                    idx_d = '0;
                end else begin
                    idx_d = idx_q;
                end
            end
            RUN: begin
                sum_d[base_s +: SLICE_W] = slice_sum_s;
                cy_d  = slice_co_s;
                idx_d = idx_q + 1'b1;
                if (last_s) begin
                    co_d  = slice_co_s;
                    // Top bit of the full sum is the MSB of the final slice.
                    ovf_d = (a_q[W-1] == b_q[W-1]) && (slice_sum_s[SLICE_W-1] != a_q[W-1]);
                end else begin
                    co_d  = co_q;
                end
            end
            default: begin
                idx_d = idx_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            cy_q  <= 1'b0;
            idx_q <= '0;
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            sum_q <= sum_d;
            cy_q  <= cy_d;
            idx_q <= idx_d;
            co_q  <= co_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.busy      = busy_s;
    assign bus.sum_out   = sum_q;
    assign bus.c_out     = co_q;
    assign bus.ovf_out   = ovf_q;

endmodule

// File: tb/tb_bigadder_seq.sv
// -----------------------------------------------------------------------------
// tb_bigadder_seq
// Scoreboard bench for bigadder_seq with WORDS=4 (64-bit operands).
// -----------------------------------------------------------------------------
module tb_bigadder_seq;

    localparam int WORDS = 4;
    localparam int W     = 64;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    exp_t exp_q[$];
    exp_t last_exp;

    bigadder_seq_if #(.WORDS(WORDS)) bus ();

    bigadder_seq #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        logic [W-1:0] beff;
        logic         c0;
        beff = sub ? ~b : b;
        c0   = sub ? 1'b1 : cin;
        {e.co, e.sum} = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, c0};
        e.ovf = (a[W-1] == beff[W-1]) && (e.sum[W-1] != a[W-1]);
        return e;
    endfunction

    // Present a job at a falling edge, let it be accepted, and record the expectation.
    task automatic start_job(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input logic sub, input bit push, input bit hold);
        @(negedge clk);
        bus.a_in     = a;
        bus.b_in     = b;
        bus.c_in     = cin;
`ifdef BIGADDER_SEQ_SUB_EN
        bus.op_sub   = sub;
`endif
        bus.in_valid = 1'b1;
        check({tag, ".in_ready"}, {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        if (push) exp_q.push_back(model(a, b, cin, sub));
        @(negedge clk);
        if (!hold) bus.in_valid = 1'b0;
        check({tag, ".busy"}, {63'd0, bus.busy}, 64'd1);
    endtask

    // Wait (bounded) for the result, check latency and scoreboard contents.
    task automatic finish_job(input string tag);
        int   lat;
        exp_t e;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(WORDS));
        if (exp_q.size() == 0) begin
            check({tag, ".sb_nonempty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            last_exp = e;
            check({tag, ".sum"}, bus.sum_out, e.sum);
            check({tag, ".c_out"}, {63'd0, bus.c_out}, {63'd0, e.co});
            check({tag, ".ovf"}, {63'd0, bus.ovf_out}, {63'd0, e.ovf});
        end
        if (bus.out_ready) begin
            @(negedge clk);
            check({tag, ".vld_drop"}, {63'd0, bus.out_valid}, 64'd0);
            check({tag, ".rdy_rise"}, {63'd0, bus.in_ready}, 64'd1);
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.c_in      = 1'b0;
`ifdef BIGADDER_SEQ_SUB_EN
        bus.op_sub    = 1'b0;
`endif
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst.in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst.out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst.busy", {63'd0, bus.busy}, 64'd0);
        check("rst.sum", bus.sum_out, 64'd0);
        check("rst.c_out", {63'd0, bus.c_out}, 64'd0);
        check("rst.ovf", {63'd0, bus.ovf_out}, 64'd0);

        // 1: basic add with carry-in
        start_job("t1", 64'h0000_0000_0000_E2A1, 64'h0000_0000_0000_1234, 1'b1, 1'b0, 1'b1, 1'b0);
        finish_job("t1");
        check("t1.sum_const", last_exp.sum, 64'h0000_0000_0000_F4D6);

        // 2: full carry ripple
        start_job("t2", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1, 1'b0);
        finish_job("t2");

        // 3: signed overflow
        start_job("t3", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1, 1'b0);
        finish_job("t3");

        // 4: backpressure with in_valid held high throughout
        bus.out_ready = 1'b0;
        start_job("t4", 64'h8000_1234_FFFF_0001, 64'h8000_0000_0001_FFFF, 1'b1, 1'b0, 1'b1, 1'b1);
        finish_job("t4");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4.hold_sum", bus.sum_out, last_exp.sum);
            check("t4.hold_co", {63'd0, bus.c_out}, {63'd0, last_exp.co});
            check("t4.hold_ovf", {63'd0, bus.ovf_out}, {63'd0, last_exp.ovf});
            check("t4.hold_vld", {63'd0, bus.out_valid}, 64'd1);
            check("t4.hold_rdy", {63'd0, bus.in_ready}, 64'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t4.hs_vld", {63'd0, bus.out_valid}, 64'd0);
        check("t4.hs_rdy", {63'd0, bus.in_ready}, 64'd1);
        check("t4.hs_busy", {63'd0, bus.busy}, 64'd0);
        @(posedge clk);
        exp_q.push_back(model(64'h8000_1234_FFFF_0001, 64'h8000_0000_0001_FFFF, 1'b1, 1'b0));
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("t4b.busy", {63'd0, bus.busy}, 64'd1);
        finish_job("t4b");

        // 5: reset while slice 2 is being processed
        start_job("t5", 64'h0000_0000_0000_E2A1, 64'h0000_0000_0000_1234, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("t5.in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("t5.out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("t5.busy", {63'd0, bus.busy}, 64'd0);
        check("t5.sum", bus.sum_out, 64'd0);
        check("t5.c_out", {63'd0, bus.c_out}, 64'd0);
        start_job("t5b", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1, 1'b0);
        finish_job("t5b");

`ifdef BIGADDER_SEQ_SUB_EN
        // 6: subtract
        start_job("t6", 64'h0000_0000_0001_0000, 64'h1, 1'b0, 1'b1, 1'b1, 1'b0);
        finish_job("t6");
        check("t6.sum_const", last_exp.sum, 64'h0000_0000_0000_FFFF);
`endif

        // Random jobs
        for (int i = 0; i < 6; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            start_job("rnd", ra, rb, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
            finish_job("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
